// File: rtl/lcd_rx_timing_decoder.sv
// Receive-side decoder for a parallel RGB565 LCD stream: recovers pixel coordinates, checks line/frame
// geometry, tracks lock and sticky errors. Define LCD_RX_CHECKSUM_EN to build the per-frame checksum.
module lcd_rx_timing_decoder #(
    parameter int H_ACTIVE        = 480,
    parameter int V_ACTIVE        = 272,
    parameter int LOCK_FRAMES     = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_en,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic [4:0]  in_r,
    input  logic [5:0]  in_g,
    input  logic [4:0]  in_b,
    input  logic        in_err_clr,
    output logic        out_pixel_valid,
    output logic [9:0]  out_pixelx,
    output logic [9:0]  out_pixely,
    output logic [15:0] out_rgb,
    output logic        out_frame_done,
    output logic [9:0]  out_frame_lines,
    output logic [15:0] out_checksum,
    output logic        out_locked,
    output logic [2:0]  out_err
);
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [10:0] LP_H    = 11'(H_ACTIVE);
    localparam logic [9:0]  LP_V    = 10'(V_ACTIVE);
    localparam logic [3:0]  LP_LOCK = 4'(LOCK_FRAMES);
    localparam logic [9:0]  LP_SAT  = 10'd1023;

    logic        w_hs_in;
    logic        w_vs_in;
    logic        r_en1, r_hs1, r_vs1, r_clr1;
    logic [15:0] r_rgb1;
    logic        r_en2, r_hs2, r_vs2, r_clr2;
    logic [15:0] r_rgb2;

    // Sync inputs are normalised so that 1 always means "asserted".
    assign w_hs_in = (SYNC_ACTIVE_LOW != 0) ? ~in_hsync : in_hsync;
    assign w_vs_in = (SYNC_ACTIVE_LOW != 0) ? ~in_vsync : in_vsync;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_en1  <= 1'b0;
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_clr1 <= 1'b0;
            r_rgb1 <= '0;
            r_en2  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_clr2 <= 1'b0;
            r_rgb2 <= '0;
        end else begin
            r_en1  <= in_en;
            r_hs1  <= w_hs_in;
            r_vs1  <= w_vs_in;
            r_clr1 <= in_err_clr;
            r_rgb1 <= {in_r, in_g, in_b};
            r_en2  <= r_en1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_clr2 <= r_clr1;
            r_rgb2 <= r_rgb1;
        end
    end

    logic w_en_rise, w_en_fall, w_vs_assert, w_hs_assert, w_unused_hs;
    assign w_en_rise   = r_en1 & ~r_en2;
    assign w_en_fall   = ~r_en1 & r_en2;
    assign w_vs_assert = r_vs1 & ~r_vs2;
    assign w_hs_assert = r_hs1 & ~r_hs2;
    // Geometry is recovered from en alone; hsync is only a timing reference here.
    assign w_unused_hs = w_hs_assert;

    logic [9:0]  r_col, r_row, r_rows_cap;
    logic        r_line_evt, r_vs_evt, r_ven_evt;
    logic [10:0] w_line_len;

    // r_col/r_row describe the pixel currently held in stage S2.
    assign w_line_len = {1'b0, r_col} + 11'd1;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rows_cap <= '0;
            r_line_evt <= 1'b0;
            r_vs_evt   <= 1'b0;
            r_ven_evt  <= 1'b0;
        end else begin
            if (w_en_rise) begin
                r_col <= '0;
            end else if (r_en1 && (r_col != LP_SAT)) begin
                r_col <= r_col + 10'd1;
            end
            if (w_vs_assert) begin
                r_row      <= '0;
                r_rows_cap <= r_row;
            end else if (w_en_fall && (r_row != LP_SAT)) begin
                r_row <= r_row + 10'd1;
            end
            r_line_evt <= w_en_fall && (w_line_len != LP_H);
            r_vs_evt   <= w_vs_assert;
            r_ven_evt  <= r_en1 & r_vs1;
        end
    end

    state_t     r_state;
    logic [3:0] r_good_cnt;
    logic       r_dirty;
    logic       w_active;
    logic [2:0] w_err_set;
    logic       w_err_event;

    // Checks are ignored in SEARCH so a partial frame after reset is discarded cleanly.
    assign w_active    = (r_state != ST_SEARCH);
    assign w_err_set   = {r_ven_evt & w_active,
                          r_vs_evt & w_active & (r_rows_cap != LP_V),
                          r_line_evt & w_active};
    assign w_err_event = |w_err_set;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state         <= ST_SEARCH;
            r_good_cnt      <= '0;
            r_dirty         <= 1'b0;
            out_pixel_valid <= 1'b0;
            out_pixelx      <= '0;
            out_pixely      <= '0;
            out_rgb         <= '0;
            out_frame_done  <= 1'b0;
            out_frame_lines <= '0;
            out_locked      <= 1'b0;
            out_err         <= '0;
        end else begin
            out_frame_done  <= r_vs_evt & w_active;
            out_pixel_valid <= r_en2 & w_active;
            if (r_vs_evt && w_active) begin
                out_frame_lines <= r_rows_cap;
            end
            if (r_en2 && w_active) begin
                out_pixelx <= r_col;
                out_pixely <= r_row;
                out_rgb    <= r_rgb2;
            end
            // A set in the same cycle as a clear wins.
            out_err <= (out_err & ~{3{r_clr2}}) | w_err_set;

            case (r_state)
                ST_SEARCH: begin
                    if (r_vs_evt) begin
                        r_state    <= ST_ACQUIRE;
                        r_good_cnt <= '0;
                        r_dirty    <= 1'b0;
                    end
                end
                default: begin
                    if (w_err_event) begin
                        r_state    <= ST_ACQUIRE;
                        r_good_cnt <= '0;
                        r_dirty    <= ~r_vs_evt;
                        out_locked <= 1'b0;
                    end else if (r_vs_evt) begin
                        // A frame that saw an error mid-way does not count towards lock.
                        if (r_dirty) begin
                            r_dirty <= 1'b0;
                        end else if (r_state == ST_ACQUIRE) begin
                            if ((r_good_cnt + 4'd1) >= LP_LOCK) begin
                                r_state    <= ST_LOCKED;
                                out_locked <= 1'b1;
                            end
                            r_good_cnt <= r_good_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef LCD_RX_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_csum;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_acc  <= '0;
            r_csum <= '0;
        end else if (r_vs_evt) begin
            if (w_active) begin
                r_csum <= r_acc;
            end
            r_acc <= '0;
        end else if (r_en2) begin
            r_acc <= r_acc + r_rgb2;
        end
    end

    assign out_checksum = r_csum;
`else
    assign out_checksum = '0;
`endif

endmodule
